// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package hilo_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam logic RD_LO = 1'b0;
  localparam logic RD_HI = 1'b1;

endpackage

// File: rtl/hilo_iter_core.sv
// One iteration of shift-add multiply or restoring divide. Purely combinational.
// Multiply: {acc_hi,acc_lo} is the product accumulator, acc_lo starts as the multiplier,
//   operand is the multiplicand.
// Divide: acc_hi is the partial remainder, acc_lo starts as the dividend and fills with
//   quotient bits from the right, operand is the divisor.
module hilo_iter_core
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             op,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Compute both candidate updates and select by operation.
  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    diff    = shifted - {1'b0, operand};
    if (op == OP_MULT) begin
      // Add then shift the whole accumulator right; the carry lands in the top bit.
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      // No borrow: keep the difference, quotient bit 1.
      nxt_hi = diff[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
    end else begin
      // Borrow: restore the shifted remainder, quotient bit 0.
      nxt_hi = shifted[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO architectural registers plus a multi-cycle unsigned multiply/divide engine.
// Fixed latency: start accepted at edge E0, HI/LO written and done pulsed after E0+WIDTH+1.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] iter_hi, iter_lo;

  hilo_iter_core #(.WIDTH(WIDTH)) u_iter (
    .op      (op_q),
    .acc_hi  (acc_hi_q),
    .acc_lo  (acc_lo_q),
    .operand (operand_q),
    .nxt_hi  (iter_hi),
    .nxt_lo  (iter_lo)
  );

  // Next-state logic: sequencing, operand capture, and HI/LO update sources.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    op_d      = op_q;
    operand_d = operand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    // Software writes only while idle; busy also covers the FINISH cycle so these never
    // collide with the result write.
    if (!busy_q) begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d      = op;
          operand_d = (op == OP_MULT) ? opa : opb;
          acc_hi_d  = '0;
          acc_lo_d  = (op == OP_MULT) ? opb : opa;
          count_d   = '0;
          busy_d    = 1'b1;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        acc_hi_d = iter_hi;
        acc_lo_d = iter_lo;
        count_d  = count_q + CNT_W'(1);
        if (count_q == LAST_ITER) state_d = S_FINISH;
      end
      S_FINISH: begin
        // Divide by zero reports 0/0 rather than the raw iteration residue.
        if (op_q == OP_DIV && operand_q == '0) begin
          hi_d = '0;
          lo_d = '0;
        end else begin
          hi_d = acc_hi_q;
          lo_d = acc_lo_q;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        count_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      op_q      <= OP_MULT;
      operand_q <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      op_q      <= op_d;
      operand_q <= operand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign rd_data = (rd_sel == RD_HI) ? hi_q : lo_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: stimulus pushes expected HI/LO and completion
// cycle, a monitor pops and checks on every done pulse.
module tb_hilo_muldiv_unit;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         rd_sel;
  logic [W-1:0] rd_data;
  logic         busy;
  logic         done;

  logic stim_sel = 1'b0;
  logic mon_sel = 1'b0;
  logic mon_active = 1'b0;
  assign rd_sel = mon_active ? mon_sel : stim_sel;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  logic prev_done = 1'b0;
  exp_t sb[$];

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .opa     (opa),
    .opb     (opb),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wdata   (wdata),
    .rd_sel  (rd_sel),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic exp_t model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    logic [2*W-1:0] p;
    if (o == 1'b0) begin
      p    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      e.hi = p[2*W-1:W];
      e.lo = p[W-1:0];
    end else if (b == '0) begin
      e.hi = '0;
      e.lo = '0;
    end else begin
      e.hi = a % b;
      e.lo = a / b;
    end
    e.due = 0;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge right after the sampling edge.
  task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit accept, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    exp_t e;
    start = 1'b1; op = o; opa = a; opb = b;
    @(negedge clk);
    start = 1'b0;
    opa = $urandom; opb = $urandom;
    $display("issue op=%0d a=0x%08h b=0x%08h accept=%0d", o, a, b, accept);
    if (accept) begin
      e.hi = ehi; e.lo = elo; e.due = cyc + W + 1;
      sb.push_back(e);
      chk("busy_after_start", {31'b0, busy}, 32'd1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total_cnt++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total_cnt++;
      $display("FAIL wait_done_timeout: got done=0 expected done=1");
    end
  endtask

  task automatic read_reg(input logic sel, output logic [W-1:0] val);
    stim_sel = sel;
    #1 val = rd_data;
  endtask

  // Monitor: every done pulse is checked against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      done_cnt++;
      total_cnt++;
      if (prev_done) $display("FAIL done_pulse: got done high 2 cycles expected 1");
      else pass_cnt++;
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("latency", cyc, e.due);
        mon_active = 1'b1;
        mon_sel = 1'b1;
        #1 chk("hi", rd_data, e.hi);
        mon_sel = 1'b0;
        #1 chk("lo", rd_data, e.lo);
        mon_active = 1'b0;
        $display("done cycle=%0d exp hi=0x%08h lo=0x%08h", cyc, e.hi, e.lo);
      end
    end
    prev_done = done;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v;
    logic [W-1:0] a, b;
    logic         o;
    exp_t         m;
    int           dc;

    rst = 1'b1; start = 1'b0; op = 1'b0; opa = '0; opb = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    read_reg(1'b1, v); chk("reset_hi", v, 32'd0);
    read_reg(1'b0, v); chk("reset_lo", v, 32'd0);

    // Idle mthi / mtlo
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678;
    @(negedge clk);
    lo_we = 1'b0;
    read_reg(1'b1, v); chk("mthi_idle", v, 32'h1234);
    read_reg(1'b0, v); chk("mtlo_idle", v, 32'h5678);
    @(negedge clk);

    // Directed operations
    issue(1'b0, 32'd7, 32'd6, 1, 32'd0, 32'd42);
    drain();
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001);
    drain();
    issue(1'b1, 32'd100, 32'd7, 1, 32'd2, 32'd14);
    drain();
    issue(1'b1, 32'h8000_0000, 32'h10, 1, 32'd0, 32'h0800_0000);
    drain();
    dc = done_cnt;
    issue(1'b1, 32'd5, 32'd0, 1, 32'd0, 32'd0);
    drain();
    chk("div0_one_done", dc + 1, done_cnt);

    // Start while busy ignored; mtlo while busy dropped
    issue(1'b0, 32'd3, 32'd4, 1, 32'd0, 32'd12);
    repeat (3) @(negedge clk);
    issue(1'b0, 32'd9, 32'd9, 0, 32'd0, 32'd0);
    lo_we = 1'b1; wdata = 32'h55;
    @(negedge clk);
    lo_we = 1'b0;
    drain();
    read_reg(1'b0, v); chk("mtlo_busy_dropped", v, 32'd12);

    // Back-to-back: second start issued in the done cycle
    issue(1'b0, 32'd13, 32'd11, 1, 32'd0, 32'd143);
    wait_done();
    issue(1'b1, 32'd1000, 32'd33, 1, 32'd10, 32'd30);
    drain();

    // Start and mthi together in idle: write lands now, result overwrites later
    hi_we = 1'b1; wdata = 32'hBEEF;
    issue(1'b0, 32'd2, 32'd3, 1, 32'd0, 32'd6);
    hi_we = 1'b0;
    read_reg(1'b1, v); chk("mthi_with_start", v, 32'hBEEF);
    drain();

    // Reset mid-operation discards everything
    hi_we = 1'b1; wdata = 32'hAA;
    @(negedge clk);
    hi_we = 1'b0;
    issue(1'b0, 32'd7, 32'd6, 0, 32'd0, 32'd0);
    repeat (9) @(negedge clk);
    dc = done_cnt;
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_done", {31'b0, done}, 32'd0);
    read_reg(1'b1, v); chk("rst_mid_hi", v, 32'd0);
    read_reg(1'b0, v); chk("rst_mid_lo", v, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst_no_done", dc, done_cnt);

    // Model-checked operands including divisor/multiplier 0, 1 and all-ones
    for (int i = 0; i < 12; i++) begin
      o = i[0];
      a = (i % 5 == 4) ? 32'hFFFF_FFFF : $urandom;
      case (i % 4)
        0: b = 32'd0;
        1: b = 32'd1;
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      m = model(o, a, b);
      issue(o, a, b, 1, m.hi, m.lo);
      if (i % 3 == 0) wait_done();
      else drain();
    end
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
